// File: rtl/sub_serial_if.sv
// sub_serial_if
//   Request/result bundle between an ALU sequencer and the serial subtractor.
//   master : drives start, a, b; observes busy, done, c and the flag set
//   slave  : the subtractor itself
//
//   start  request, honoured only while the unit is idle or in its done cycle
//   a, b   minuend / subtrahend, captured on the accepting edge only
//   busy   operation in progress
//   done   one-cycle pulse, c and flags valid
//   c      a - b mod 2^WIDTH
//   s, zr, cy, p, v   sign, zero, borrow, even parity, signed overflow
interface sub_serial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] c;
    logic             s;
    logic             zr;
    logic             cy;
    logic             p;
    logic             v;

    modport master (
        output start, a, b,
        input  busy, done, c, s, zr, cy, p, v
    );

    modport slave (
        input  start, a, b,
        output busy, done, c, s, zr, cy, p, v
    );
endinterface

// File: rtl/sub_serial_unit.sv
// sub_serial_unit
//   Digit-serial subtractor: c = a - b, DIGIT bits per clock, LSB slice first,
//   with the same five-flag set as the combinational adder unit so the ALU
//   flag logic can take either source.  WIDTH must be a multiple of DIGIT;
//   latency from the accepting edge to done is WIDTH/DIGIT clocks.
//
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset; clears every output and aborts
//          any operation in flight (it also beats a simultaneous start)
//   bus    sub_serial_if slave modport (start/a/b in; busy/done/c/flags out)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; c and flags hold the last result
//   RUN    | one slice of a - b per edge, borrow carried between slices
//   DONE   | single cycle, done=1; start here is accepted back-to-back
module sub_serial_unit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    sub_serial_if.slave bus
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0]    LAST_SLICE = CW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'((64'd1 << DIGIT) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_step;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_s;
    logic             r_zr;
    logic             r_cy;
    logic             r_p;
    logic             r_v;

    logic [31:0]      w_shamt;
    logic [DIGIT-1:0] w_a_sl;
    logic [DIGIT-1:0] w_b_sl;
    logic [DIGIT:0]   w_diff;
    logic [WIDTH-1:0] w_c_new;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-cycle control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // start is deliberately not looked at here: no queueing
                w_step = 1'b1;
                if (r_cnt == LAST_SLICE) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slice arithmetic.  The difference is taken one DIGIT wide with one
    // guard bit; the guard bit of (a_sl - b_sl - borrow) is the borrow out.
    // ------------------------------------------------------------------
    assign w_shamt = 32'(r_cnt) * 32'(DIGIT);
    assign w_a_sl  = DIGIT'(r_a >> w_shamt);
    assign w_b_sl  = DIGIT'(r_b >> w_shamt);
    assign w_diff  = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{DIGIT{1'b0}}, r_borrow};

    // Slice written in place so slices not yet reached keep their old value
    assign w_c_new = (r_c & ~(SLICE_MASK << w_shamt))
                   | (WIDTH'(w_diff[DIGIT-1:0]) << w_shamt);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_s      <= 1'b0;
            r_zr     <= 1'b0;
            r_cy     <= 1'b0;
            r_p      <= 1'b0;
            r_v      <= 1'b0;
        end else if (w_accept) begin
            // c is left alone: it is overwritten slice by slice
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else if (w_step) begin
            r_c      <= w_c_new;
            r_borrow <= w_diff[DIGIT];
            r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                // flags move together, from the completed result only
                r_s  <= w_c_new[WIDTH-1];
                r_zr <= (w_c_new == '0);
                r_cy <= w_diff[DIGIT];
                r_p  <= ~^w_c_new;
                r_v  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &
                        (w_c_new[WIDTH-1] != r_a[WIDTH-1]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.c    = r_c;
    assign bus.s    = r_s;
    assign bus.zr   = r_zr;
    assign bus.cy   = r_cy;
    assign bus.p    = r_p;
    assign bus.v    = r_v;

endmodule
